// File: rtl/wb_arb2.sv
// Two-master to one-slave Wishbone arbiter with a registered grant and a bus watchdog.
// Define ARB_RR_EN for round-robin on simultaneous requests; M0 has fixed priority otherwise.
module wb_arb2 #(
  parameter int unsigned AW      = 19,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [AW:1]       wbm0_adr_i,
  input  logic [DW-1:0]     wbm0_dat_i,
  output logic [DW-1:0]     wbm0_dat_o,
  input  logic [DW/8-1:0]   wbm0_sel_i,
  input  logic              wbm0_we_i,
  input  logic              wbm0_stb_i,
  input  logic              wbm0_cyc_i,
  output logic              wbm0_ack_o,
  output logic              wbm0_err_o,
  input  logic [AW:1]       wbm1_adr_i,
  input  logic [DW-1:0]     wbm1_dat_i,
  output logic [DW-1:0]     wbm1_dat_o,
  input  logic [DW/8-1:0]   wbm1_sel_i,
  input  logic              wbm1_we_i,
  input  logic              wbm1_stb_i,
  input  logic              wbm1_cyc_i,
  output logic              wbm1_ack_o,
  output logic              wbm1_err_o,
  output logic [AW:1]       wbs_adr_o,
  output logic [DW-1:0]     wbs_dat_o,
  input  logic [DW-1:0]     wbs_dat_i,
  output logic [DW/8-1:0]   wbs_sel_o,
  output logic              wbs_we_o,
  output logic              wbs_stb_o,
  output logic              wbs_cyc_o,
  input  logic              wbs_ack_i,
  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

  localparam int unsigned   WdW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  state_e         state_q, state_d, both_pick;
  logic [WdW-1:0] wd_q, wd_d;
  logic           sel0, sel1, stb_raw, cyc_raw, wd_hit;

`ifdef ARB_RR_EN
  // last_q: 0 = M0 served last, 1 = M1 served last.
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_d == StG0 && state_q != StG0) last_d = 1'b0;
    if (state_d == StG1 && state_q != StG1) last_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) last_q <= 1'b1;
    else          last_q <= last_d;
  end

  assign both_pick = last_q ? StG0 : StG1;
`else
  assign both_pick = StG0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wbm0_cyc_i && wbm1_cyc_i) state_d = both_pick;
        else if (wbm0_cyc_i)          state_d = StG0;
        else if (wbm1_cyc_i)          state_d = StG1;
      end
      StG0:    if (!wbm0_cyc_i) state_d = wbm1_cyc_i ? StG1 : StIdle;
      StG1:    if (!wbm1_cyc_i) state_d = wbm0_cyc_i ? StG0 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Reset gates every slave-facing output and every ack/err immediately.
  assign sel0    = (state_q == StG0) && !wb_rst_i;
  assign sel1    = (state_q == StG1) && !wb_rst_i;
  assign stb_raw = (sel0 && wbm0_stb_i) || (sel1 && wbm1_stb_i);
  assign cyc_raw = (sel0 && wbm0_cyc_i) || (sel1 && wbm1_cyc_i);
  assign wd_hit  = (TIMEOUT != 0) && stb_raw && cyc_raw && !wbs_ack_i && (wd_q == WdLast);

  always_comb begin
    wd_d = wd_q + WdW'(1);
    if (TIMEOUT == 0 || wbs_ack_i || !(stb_raw && cyc_raw) || wd_hit) wd_d = '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    if (sel0) begin
      wbs_adr_o = wbm0_adr_i;
      wbs_dat_o = wbm0_dat_i;
      wbs_sel_o = wbm0_sel_i;
      wbs_we_o  = wbm0_we_i;
    end else if (sel1) begin
      wbs_adr_o = wbm1_adr_i;
      wbs_dat_o = wbm1_dat_i;
      wbs_sel_o = wbm1_sel_i;
      wbs_we_o  = wbm1_we_i;
    end
  end

  assign wbs_cyc_o  = cyc_raw;
  assign wbs_stb_o  = stb_raw && !wd_hit;
  assign wbm0_ack_o = wbs_ack_i && sel0 && wbm0_stb_i;
  assign wbm1_ack_o = wbs_ack_i && sel1 && wbm1_stb_i;
  assign wbm0_err_o = wd_hit && sel0;
  assign wbm1_err_o = wd_hit && sel1;
  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign gnt_o      = {state_q == StG1, state_q == StG0};

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: vector table for arbitration/muxing, plus watchdog,
// reset and simultaneous-request sequences.
module tb_wb_arb2;

  localparam logic [18:0] A0 = 19'h12345;
  localparam logic [18:0] A1 = 19'h00100;
  localparam logic [15:0] D0 = 16'h1111;
  localparam logic [15:0] D1 = 16'h2222;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:1] m0_adr, m1_adr, s_adr;
  logic [15:0] m0_dw, m1_dw, m0_dr, m1_dr, s_dw, s_dr;
  logic [1:0]  m0_sel, m1_sel, s_sel, gnt;
  logic        m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
  logic        m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
  logic        s_we, s_stb, s_cyc, s_ack;

  always #5 clk = ~clk;

  wb_arb2 #(.AW(19), .DW(16), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dw), .wbm0_dat_o(m0_dr), .wbm0_sel_i(m0_sel),
    .wbm0_we_i(m0_we), .wbm0_stb_i(m0_stb), .wbm0_cyc_i(m0_cyc), .wbm0_ack_o(m0_ack),
    .wbm0_err_o(m0_err),
    .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dw), .wbm1_dat_o(m1_dr), .wbm1_sel_i(m1_sel),
    .wbm1_we_i(m1_we), .wbm1_stb_i(m1_stb), .wbm1_cyc_i(m1_cyc), .wbm1_ack_o(m1_ack),
    .wbm1_err_o(m1_err),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dw), .wbs_dat_i(s_dr), .wbs_sel_o(s_sel),
    .wbs_we_o(s_we), .wbs_stb_o(s_stb), .wbs_cyc_o(s_cyc), .wbs_ack_i(s_ack),
    .gnt_o(gnt)
  );

  typedef struct {
    logic [3:0]  req;  // {m0_cyc, m0_stb, m1_cyc, m1_stb}
    logic        ack;
    logic [1:0]  gnt;
    logic        cyc;
    logic        stb;
    logic [18:0] adr;
    logic [15:0] dat;
    logic        a0;
    logic        a1;
  } vec_t;

  vec_t vt[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic vec_t mkv(logic [3:0] req, logic ack, logic [1:0] g, logic cyc, logic stb,
                               logic [18:0] adr, logic [15:0] dat, logic a0, logic a1);
    vec_t v;
    v.req = req; v.ack = ack; v.gnt = g; v.cyc = cyc; v.stb = stb;
    v.adr = adr; v.dat = dat; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic ack);
    {m0_cyc, m0_stb, m1_cyc, m1_stb} = req;
    s_ack = ack;
  endtask

  initial begin
    m0_adr = A0; m0_dw = D0; m0_sel = 2'b01; m0_we = 1'b0;
    m1_adr = A1; m1_dw = D1; m1_sel = 2'b10; m1_we = 1'b0;
    s_dr = 16'hBEEF;
    drive(4'b0000, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_gnt", 64'(gnt), 64'd0);
    chk("reset_cyc", 64'({s_cyc, s_stb, m0_ack, m1_ack}), 64'd0);
    step();

    // M1 read with 2-cycle slave latency.
    vt.push_back(mkv(4'b0011, 0, 2'b00, 0, 0, 0,  0,  0, 0));
    vt.push_back(mkv(4'b0011, 0, 2'b10, 1, 1, A1, D1, 0, 0));
    vt.push_back(mkv(4'b0011, 0, 2'b10, 1, 1, A1, D1, 0, 0));
    vt.push_back(mkv(4'b0011, 1, 2'b10, 1, 1, A1, D1, 0, 1));
    vt.push_back(mkv(4'b0000, 0, 2'b10, 0, 0, A1, D1, 0, 0));
    vt.push_back(mkv(4'b0000, 0, 2'b00, 0, 0, 0,  0,  0, 0));
    // Simultaneous requests: M0 first, M1 on the cycle after M0 drops cyc.
    vt.push_back(mkv(4'b1111, 0, 2'b00, 0, 0, 0,  0,  0, 0));
    vt.push_back(mkv(4'b1111, 0, 2'b01, 1, 1, A0, D0, 0, 0));
    vt.push_back(mkv(4'b1111, 1, 2'b01, 1, 1, A0, D0, 1, 0));
    vt.push_back(mkv(4'b0011, 0, 2'b01, 0, 0, A0, D0, 0, 0));
    vt.push_back(mkv(4'b0011, 0, 2'b10, 1, 1, A1, D1, 0, 0));
    vt.push_back(mkv(4'b0011, 1, 2'b10, 1, 1, A1, D1, 0, 1));
    vt.push_back(mkv(4'b0000, 0, 2'b10, 0, 0, A1, D1, 0, 0));
    vt.push_back(mkv(4'b0000, 0, 2'b00, 0, 0, 0,  0,  0, 0));
    // M0 4-beat burst while M1 waits.
    vt.push_back(mkv(4'b1111, 0, 2'b00, 0, 0, 0,  0,  0, 0));
    for (int b = 0; b < 4; b++) vt.push_back(mkv(4'b1111, 1, 2'b01, 1, 1, A0, D0, 1, 0));
    vt.push_back(mkv(4'b0011, 0, 2'b01, 0, 0, A0, D0, 0, 0));
    vt.push_back(mkv(4'b0011, 0, 2'b10, 1, 1, A1, D1, 0, 0));
    vt.push_back(mkv(4'b0000, 0, 2'b10, 0, 0, A1, D1, 0, 0));
    vt.push_back(mkv(4'b0000, 0, 2'b00, 0, 0, 0,  0,  0, 0));

    foreach (vt[i]) begin
      drive(vt[i].req, vt[i].ack);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({gnt, s_cyc, s_stb, 19'(s_adr), s_dw, m0_ack, m1_ack}),
          64'({vt[i].gnt, vt[i].cyc, vt[i].stb, vt[i].adr, vt[i].dat, vt[i].a0, vt[i].a1}));
      step();
    end
    chk("rd_data", 64'({m0_dr, m1_dr}), 64'({16'hBEEF, 16'hBEEF}));

    // Watchdog: M1 write never acked; err on the 8th stb cycle, then restarts.
    m1_we = 1'b1;
    drive(4'b0011, 1'b0);
    @(negedge clk);
    chk("wd_latency_stb", 64'(s_stb), 64'd0);
    step();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("wd_k%0d", k), 64'({m1_err, m0_err, s_stb, s_cyc, s_we, s_sel}),
          64'({(k % 8) == 7, 1'b0, (k % 8) != 7, 1'b1, 1'b1, 2'b10}));
      step();
    end
    drive(4'b0000, 1'b0);
    m1_we = 1'b0;
    step();
    step();

    // Reset in the middle of an M0 read.
    drive(4'b1100, 1'b0);
    step();
    @(negedge clk);
    chk("rst_pre_cyc", 64'({gnt, s_cyc}), 64'({2'b01, 1'b1}));
    step();
    rst   = 1'b1;
    s_ack = 1'b1;
    @(negedge clk);
    chk("rst_during", 64'({s_cyc, s_stb, m0_ack, m0_err, 19'(s_adr)}), 64'd0);
    step();
    chk("rst_next_gnt", 64'({gnt, s_cyc, m0_ack}), 64'd0);
    rst = 1'b0;
    drive(4'b0011, 1'b0);
    @(negedge clk);
    chk("rst_after_idle", 64'(gnt), 64'd0);
    step();
    @(negedge clk);
    chk("rst_after_g1", 64'({gnt, s_stb, 19'(s_adr)}), 64'({2'b10, 1'b1, A1}));
    drive(4'b0000, 1'b0);
    step();
    step();

    // M0 served last, then simultaneous requests from IDLE.
    drive(4'b1100, 1'b0);
    step();
    s_ack = 1'b1;
    step();
    drive(4'b0000, 1'b0);
    step();
    drive(4'b1111, 1'b0);
    step();
    @(negedge clk);
`ifdef ARB_RR_EN
    chk("both_after_m0", 64'(gnt), 64'(2'b10));
`else
    chk("both_after_m0", 64'(gnt), 64'(2'b01));
`endif
    drive(4'b0000, 1'b0);
    step();
    step();
    @(negedge clk);
    chk("final_idle", 64'({gnt, s_cyc}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
